// File: rtl/nibbler_pkg.sv
// nibbler_pkg: shared opcode, state, bus-select and ALU-mode definitions for the Nibbler CPU
package nibbler_pkg;
   typedef enum logic [3:0] {
      OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP, OP_LD, OP_ST, OP_ADDM,
      OP_LIT, OP_ADDI, OP_CMPI, OP_SUBI, OP_NORI, OP_IN, OP_OUT, OP_NOP
   } opcode_t;
   typedef enum logic [1:0] {FETCH0, FETCH1, EXEC} state_t;
   typedef enum logic [1:0] {BUS_IMM = 2'b00, BUS_MEM = 2'b01, BUS_IN = 2'b10} bus_sel_t;
   localparam logic [2:0] ALU_PASS_A   = 3'b000;
   localparam logic [2:0] ALU_SUB      = 3'b001;
   localparam logic [2:0] ALU_PASS_BUS = 3'b010;
   localparam logic [2:0] ALU_ADD      = 3'b011;
   localparam logic [2:0] ALU_NOR      = 3'b100;
endpackage

// File: rtl/nibbler_pc.sv
// nibbler_pc: program counter register with increment and jump load (load wins)
module nibbler_pc #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              notReset,
   input  logic              inc,
   input  logic              load,
   input  logic [ADDR_W-1:0] d,
   output logic [ADDR_W-1:0] q
);
   always_ff @(posedge clk or negedge notReset)
      if (!notReset) q <= '0;
      else if (load) q <= d;
      else if (inc) q <= q + 1'b1;
endmodule

// File: rtl/nibbler_control_unit.sv
// nibbler_control_unit: fetch/decode sequencer driving the Nibbler ALU, memories and flags
module nibbler_control_unit
   import nibbler_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int N      = 4
) (
   input  logic              clk,
   input  logic              notReset,
   input  logic [7:0]        instr,
   input  logic              notC,
   input  logic              notZ,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [ADDR_W-1:0] pc,
   output logic [2:0]        S,
   output logic              notCarryIn,
   output logic              loadA,
   output logic              loadOut,
   output logic [1:0]        busSel,
   output logic [N-1:0]      operand,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic              dmem_we,
   output logic [1:0]        flags
);
   state_t state, state_nx;
   opcode_t op;
   logic [7:0] ir, addr_lo;
   logic take, flag_en;
   assign op = opcode_t'(ir[7:4]);
   assign imem_addr = pc;
   assign operand = ir[N-1:0];
   assign dmem_addr = {ir[3:0], addr_lo};
   // opcodes 0-7 carry a second byte (addr_lo)
   assign state_nx = state == FETCH0 ? (instr[7] ? EXEC : FETCH1) :
                     state == FETCH1 ? EXEC : FETCH0;
   always_ff @(posedge clk or negedge notReset)
      if (!notReset) begin
         state   <= FETCH0;
         ir      <= '0;
         addr_lo <= '0;
         flags   <= 2'b11;
      end else begin
         state <= state_nx;
         if (state == FETCH0) ir <= instr;
         if (state == FETCH1) addr_lo <= instr;
         if (flag_en) flags <= {notC, notZ};
      end
   always_comb begin
      S          = ALU_PASS_A;
      notCarryIn = 1'b1;
      busSel     = BUS_IMM;
      loadA      = 1'b0;
      loadOut    = 1'b0;
      dmem_we    = 1'b0;
      flag_en    = 1'b0;
      take       = 1'b0;
      if (state == EXEC)
         case (op)
            OP_JC:   take = !flags[1];
            OP_JNC:  take = flags[1];
            OP_JZ:   take = !flags[0];
            OP_JNZ:  take = flags[0];
            OP_JMP:  take = 1'b1;
            OP_LD:   begin S = ALU_PASS_BUS; busSel = BUS_MEM; loadA = 1'b1; flag_en = 1'b1; end
            OP_ST:   dmem_we = 1'b1;
            OP_ADDM: begin S = ALU_ADD; busSel = BUS_MEM; loadA = 1'b1; flag_en = 1'b1; end
            OP_LIT:  begin S = ALU_PASS_BUS; loadA = 1'b1; flag_en = 1'b1; end
            OP_ADDI: begin S = ALU_ADD; loadA = 1'b1; flag_en = 1'b1; end
            OP_CMPI: begin S = ALU_SUB; notCarryIn = 1'b0; flag_en = 1'b1; end
            OP_SUBI: begin S = ALU_SUB; notCarryIn = 1'b0; loadA = 1'b1; flag_en = 1'b1; end
            OP_NORI: begin S = ALU_NOR; loadA = 1'b1; flag_en = 1'b1; end
            OP_IN:   begin S = ALU_PASS_BUS; busSel = BUS_IN; loadA = 1'b1; flag_en = 1'b1; end
            OP_OUT:  loadOut = 1'b1;
            default: ;
         endcase
   end
   nibbler_pc #(.ADDR_W(ADDR_W)) u_pc (
      .clk      (clk),
      .notReset (notReset),
      .inc      (state != EXEC),
      .load     (take),
      .d        ({ir[3:0], addr_lo}),
      .q        (pc)
   );
endmodule

// File: doc/nibbler_control_unit.md
Name: nibbler_control_unit

Overview:
Instruction sequencer for the 4-bit Nibbler CPU. It is the controlling end of the ALU interface: it fetches instruction bytes from program ROM and decodes them into the ALU mode select (notCarryIn, S), accumulator/output load strobes, bus source and data-memory controls. It registers the ALU flags (notC, notZ) and uses them to resolve conditional jumps. It sits between program ROM, data RAM and the datapath (ALU, accumulator, output latch).

Parameters:
ADDR_W, 12, program/data address width in bits
N, 4, datapath width; must match the ALU

Ports:
clk  input  1  system clock, all state changes on the rising edge
notReset  input  1  asynchronous, active-low reset
instr  input  8  program ROM data; combinational read of imem_addr, valid in the same cycle
notC  input  1  ALU carry flag, active-low
notZ  input  1  ALU zero flag, active-low (0 = result zero)
imem_addr  output  ADDR_W  program ROM address; equals pc
pc  output  ADDR_W  program counter
S  output  3  ALU mode select
notCarryIn  output  1  ALU carry-in, active-low
loadA  output  1  accumulator load strobe
loadOut  output  1  output-port latch strobe
busSel  output  2  data_bus source: 00 IMM (operand), 01 MEM, 10 IN port
operand  output  N  immediate nibble, IR[3:0]
dmem_addr  output  ADDR_W  data RAM address, {IR[3:0], addr_lo}
dmem_we  output  1  data RAM write strobe
flags  output  2  registered {notC, notZ}

Behaviour:
- Reset (asynchronous, notReset=0 at any time, including mid-instruction): state=FETCH0, pc=0, IR=0, addr_lo=0, flags=2'b11. All strobes (loadA, loadOut, dmem_we) are 0; S=000, notCarryIn=1, busSel=IMM.
- Format: byte0={opcode[7:4], imm[3:0]}. Two-byte ops add byte1=addr_lo; target/address={imm, addr_lo}.
- FSM states: FETCH0, FETCH1, EXEC.
  - FETCH0: IR<=instr; pc<=pc+1. Go to FETCH1 if opcode<=7, else EXEC.
  - FETCH1: addr_lo<=instr; pc<=pc+1; go to EXEC.
  - EXEC: decode outputs active for exactly one cycle; go to FETCH0.
- Latency: one-byte instructions take 2 cycles; two-byte instructions take 3.
- Strobes and dmem_we are asserted only in EXEC. Decode outputs are combinational from state and IR. In fetch states, S/notCarryIn/busSel hold their reset values.
- Opcodes (S / notCarryIn / busSel / loadA / flag update):
  - 0 JC: taken if notC=0.
  - 1 JNC: taken if notC=1.
  - 2 JZ: taken if notZ=0.
  - 3 JNZ: taken if notZ=1.
  - 4 JMP: always taken.
  - 5 LD: 010 / 1 / MEM / 1 / yes.
  - 6 ST: dmem_we=1, no ALU activity.
  - 7 ADDM: 011 / 1 / MEM / 1 / yes.
  - 8 LIT: 010 / 1 / IMM / 1 / yes.
  - 9 ADDI: 011 / 1 / IMM / 1 / yes.
  - A CMPI: 001 / 0 / IMM / 0 / yes.
  - B SUBI: 001 / 0 / IMM / 1 / yes.
  - C NORI: 100 / 1 / IMM / 1 / yes.
  - D IN: 010 / 1 / IN / 1 / yes.
  - E OUT: 000 / 1 / IMM / loadOut=1 / no.
  - F NOP: nothing.
- Jumps: when taken, pc<={imm, addr_lo} at the end of EXEC; otherwise pc is unchanged (already points at the next instruction). Jumps read the registered flags, never the live ALU inputs.
- Flag update: flags<={notC, notZ} on the rising edge that ends EXEC, for flagged ops only. A jump that immediately follows an ALU op therefore sees the new flags.
- pc arithmetic: modulo 2^ADDR_W; 0xFFF+1 wraps to 0x000. A two-byte op at 0xFFF fetches addr_lo from 0x000.
- Simultaneous events: a jump load overrides the increment only in EXEC; fetch states always increment. There is no stall input; ROM and RAM are zero-wait.

Decomposition:
- Package nibbler_pkg holds:
  - opcode_t enum (the 16 opcodes above)
  - state_t enum (FETCH0/FETCH1/EXEC)
  - bus_sel_t enum (IMM/MEM/IN)
  - ALU select constants: ALU_PASS_A=000, ALU_SUB=001, ALU_PASS_BUS=010, ALU_ADD=011, ALU_NOR=100
- One sub-module, nibbler_pc: ADDR_W-bit register with async active-low reset, inc and load inputs, load priority.

Test Plan:
- Assert notReset=0 during EXEC of ADDI -> pc=0x000, state=FETCH0, loadA=0, flags=11, S=000, notCarryIn=1, all immediately (asynchronously).
- ROM 0x000: 0x85 (LIT 5) -> cycle 2 has S=010, busSel=IMM, operand=5, loadA=1 for exactly one cycle; pc=0x001 afterwards.
- ADDI 0xC with ALU driving notC=0, then JC 0x3,0x45 -> flags=01 latched; pc=0x345 after 3 cycles; the next fetch is from 0x345.
- With flags notZ=0, execute JNZ 0x1,0x00 at 0x010 -> not taken; pc=0x012; no strobes asserted.
- ST 0x1,0x23 -> dmem_addr=0x123, dmem_we=1 for exactly one cycle (EXEC); loadA=0; flags unchanged.
- NOP at 0xFFF -> pc=0x000. JMP at 0xFFF with ROM[0x000]=0x20 -> target {imm,0x20}; CMPI -> loadA=0 and flags updated.
